// File: rtl/odd_pipe_stage_chain_if.sv
// -----------------------------------------------------------------------------
// odd_pipe_stage_chain_if
//
// Bundles the issue, control, forwarding and writeback signals of the odd-pipe
// result-staging chain. Clock and reset stay plain ports on the chain itself.
//
// Signals:
//   issue_valid/unit/data/dst/lat/wr  result presented by an odd execution unit
//   issue_ready                       high when the chain accepts an issue
//   stall, flush                      global freeze / branch squash
//   fwd_addr                          NUM_FWD packed lookup addresses
//   fwd_hit/fwd_pending/fwd_data      per-port forwarding results
//   wb_en/wb_addr/wb_data             registered register-file write port
//   empty                             no valid entry anywhere in the chain
//
// Modports:
//   master  upstream side (drives issue/control/lookups)
//   slave   the staging chain
// -----------------------------------------------------------------------------
interface odd_pipe_stage_chain_if #(
   parameter int DATA_W  = 128,
   parameter int REG_AW  = 7,
   parameter int UNIT_W  = 3,
   parameter int LAT_W   = 4,
   parameter int NUM_FWD = 3
);
   logic                      issue_valid;
   logic [UNIT_W-1:0]         issue_unit;
   logic [DATA_W-1:0]         issue_data;
   logic [REG_AW-1:0]         issue_dst;
   logic [LAT_W-1:0]          issue_lat;
   logic                      issue_wr;
   logic                      issue_ready;
   logic                      stall;
   logic                      flush;
   logic [NUM_FWD*REG_AW-1:0] fwd_addr;
   logic [NUM_FWD-1:0]        fwd_hit;
   logic [NUM_FWD-1:0]        fwd_pending;
   logic [NUM_FWD*DATA_W-1:0] fwd_data;
   logic                      wb_en;
   logic [REG_AW-1:0]         wb_addr;
   logic [DATA_W-1:0]         wb_data;
   logic                      empty;

   modport master (
      output issue_valid, issue_unit, issue_data, issue_dst, issue_lat, issue_wr,
      output stall, flush, fwd_addr,
      input  issue_ready, fwd_hit, fwd_pending, fwd_data,
      input  wb_en, wb_addr, wb_data, empty
   );

   modport slave (
      input  issue_valid, issue_unit, issue_data, issue_dst, issue_lat, issue_wr,
      input  stall, flush, fwd_addr,
      output issue_ready, fwd_hit, fwd_pending, fwd_data,
      output wb_en, wb_addr, wb_data, empty
   );
endinterface

// File: rtl/odd_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// odd_pipe_stage_chain
//
// Result-staging chain between the odd execution units (permute, load/store,
// branch) and the register-file write port. One packed result per cycle enters
// stage 1 and advances one stage per unstalled cycle through DEPTH stages,
// then into a registered writeback slot. Each entry carries a latency tag; an
// entry in stage k is forwardable once k >= lat. NUM_FWD independent lookup
// ports return the youngest matching entry, or flag a hazard when that
// youngest match is not yet forwardable.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   odd_pipe_stage_chain_if.slave (issue, stall/flush, forwarding, wb)
//
// Parameters:
//   DATA_W, REG_AW, UNIT_W, LAT_W  field widths
//   DEPTH        number of staging stages (2..15)
//   NUM_FWD      number of forwarding lookup ports
//   FLUSH_DEPTH  number of youngest stages squashed by flush (0 = issue only)
// -----------------------------------------------------------------------------
module odd_pipe_stage_chain #(
   parameter int DATA_W      = 128,
   parameter int REG_AW      = 7,
   parameter int UNIT_W      = 3,
   parameter int LAT_W       = 4,
   parameter int DEPTH       = 7,
   parameter int NUM_FWD     = 3,
   parameter int FLUSH_DEPTH = 0
) (
   input logic                    clk,
   input logic                    rst,
   odd_pipe_stage_chain_if.slave  bus
);

   // A flush deep enough to cover the last stage also squashes the entry
   // that would otherwise move into the writeback register.
   localparam logic FLUSH_REACHES_WB = (FLUSH_DEPTH >= DEPTH);

   typedef struct packed {
      logic              valid;
      logic [UNIT_W-1:0] unit;
      logic [DATA_W-1:0] data;
      logic [REG_AW-1:0] dst;
      logic [LAT_W-1:0]  lat;
      logic              wr;
   } stage_t;

   typedef struct packed {
      logic              hit;
      logic              pending;
      logic [DATA_W-1:0] data;
   } fwd_t;

   stage_t                    r_stage [1:DEPTH];
   logic                      r_wb_en;
   logic [REG_AW-1:0]         r_wb_addr;
   logic [DATA_W-1:0]         r_wb_data;

   stage_t                    w_issue;
   logic [DEPTH:1]            w_valid;
   logic [DEPTH:1]            w_ready;
   logic [NUM_FWD-1:0]        w_fwd_hit;
   logic [NUM_FWD-1:0]        w_fwd_pending;
   logic [NUM_FWD*DATA_W-1:0] w_fwd_data;

   // The unit id travels with each entry for trace/debug visibility; the copy
   // in the last stage is not consumed by the writeback port.
   logic                      w_unused_unit;
   assign w_unused_unit = ^r_stage[DEPTH].unit;

   // ---------------------------------------------------------------------------
   // Issue slot: a flush kills the result being issued in the same cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_issue.valid = bus.issue_valid & ~bus.flush;
      w_issue.unit  = bus.issue_unit;
      w_issue.data  = bus.issue_data;
      w_issue.dst   = bus.issue_dst;
      w_issue.lat   = bus.issue_lat;
      w_issue.wr    = bus.issue_wr;
   end

   // ---------------------------------------------------------------------------
   // Stage chain and writeback register.
   // Under stall everything holds except wb_en, which drops so a result that
   // was just written is not written a second time.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the stage array is reset entry by entry because in-flight
         // results must vanish on reset and the forwarding logic reads every
         // stage; a non-reset array would leak stale matches after reset.
         for (int k = 1; k <= DEPTH; k++) begin
            r_stage[k] <= '0;
         end
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else if (bus.stall) begin
         r_wb_en <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample its
         // predecessor's old value, so the loop order does not matter.
         r_stage[1] <= w_issue;
         for (int k = 1; k < DEPTH; k++) begin
            r_stage[k+1] <= r_stage[k];
            // Squash the youngest FLUSH_DEPTH stages as they advance.
            if (bus.flush && (k <= FLUSH_DEPTH)) begin
               r_stage[k+1].valid <= 1'b0;
            end
         end
         r_wb_en   <= r_stage[DEPTH].valid & r_stage[DEPTH].wr
                      & ~(bus.flush & FLUSH_REACHES_WB);
         r_wb_addr <= r_stage[DEPTH].dst;
         r_wb_data <= r_stage[DEPTH].data;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-stage valid and ready flags. Ready is an unsigned k >= lat compare, so
   // lat=0 is ready in stage 1 and lat>DEPTH never becomes ready in the chain.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int k = 1; k <= DEPTH; k++) begin
         w_valid[k] = r_stage[k].valid;
         w_ready[k] = (32'(r_stage[k].lat) <= 32'(k));
      end
   end

   // ---------------------------------------------------------------------------
   // Forwarding lookup for one address. The scan runs from the oldest source
   // (wb register) to the youngest (stage 1) so the last match kept is the
   // youngest one; only that entry decides hit versus pending.
   // ---------------------------------------------------------------------------
   function automatic fwd_t lookup(input logic [REG_AW-1:0] addr);
      fwd_t              res;
      logic              found;
      logic              rdy;
      logic [DATA_W-1:0] dat;
      found = r_wb_en && (r_wb_addr == addr);
      rdy   = 1'b1;
      dat   = r_wb_data;
      for (int k = DEPTH; k >= 1; k--) begin
         if (r_stage[k].valid && r_stage[k].wr && (r_stage[k].dst == addr)) begin
            found = 1'b1;
            rdy   = w_ready[k];
            dat   = r_stage[k].data;
         end
      end
      res.hit     = found & rdy;
      res.pending = found & ~rdy;
      res.data    = (found & rdy) ? dat : '0;
      return res;
   endfunction

   always_comb begin
      fwd_t w_res;
      // NOTE: every combinational output gets a default before the loop so no
      // path through the block leaves a value unassigned (no latches).
      w_fwd_hit     = '0;
      w_fwd_pending = '0;
      w_fwd_data    = '0;
      w_res         = '0;
      for (int i = 0; i < NUM_FWD; i++) begin
         w_res                          = lookup(bus.fwd_addr[i*REG_AW +: REG_AW]);
         w_fwd_hit[i]                   = w_res.hit;
         w_fwd_pending[i]               = w_res.pending;
         w_fwd_data[i*DATA_W +: DATA_W] = w_res.data;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.issue_ready = ~bus.stall;
   assign bus.fwd_hit     = w_fwd_hit;
   assign bus.fwd_pending = w_fwd_pending;
   assign bus.fwd_data    = w_fwd_data;
   assign bus.wb_en       = r_wb_en;
   assign bus.wb_addr     = r_wb_addr;
   assign bus.wb_data     = r_wb_data;
   assign bus.empty       = ~(|w_valid) & ~r_wb_en;

endmodule
